// File: rtl/gyro_frame_packer.sv
// rtl/gyro_frame_packer.sv - periodic gyro snapshot serialised as an 11-byte checksummed UART frame
// Frame: SYNC0 SYNC1 xL xH yL yH zL zH tL tH csum, csum = 8-bit sum of the eight data bytes.
module gyro_frame_packer #(
  parameter int unsigned PERIOD      = 1000000,
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter logic [7:0]  SYNC0       = 8'hA5,
  parameter logic [7:0]  SYNC1       = 8'h5A
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        en,
  input  logic [15:0] temp_data,
  input  logic [15:0] x_axis_data,
  input  logic [15:0] y_axis_data,
  input  logic [15:0] z_axis_data,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]       LAST_IDX = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       idx_q, idx_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [15:0]      snap_x_q, snap_y_q, snap_z_q, snap_t_q;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       ovr_q;
  logic             tick;
  logic             capture;
  logic             byte_done;
  logic [7:0]       csum;
  logic [7:0]       cur_byte;

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    csum = snap_x_q[7:0] + snap_x_q[15:8] + snap_y_q[7:0] + snap_y_q[15:8]
         + snap_z_q[7:0] + snap_z_q[15:8] + snap_t_q[7:0] + snap_t_q[15:8];
    case (idx_q)
      4'd0:    cur_byte = SYNC0;
      4'd1:    cur_byte = SYNC1;
      4'd2:    cur_byte = snap_x_q[7:0];
      4'd3:    cur_byte = snap_x_q[15:8];
      4'd4:    cur_byte = snap_y_q[7:0];
      4'd5:    cur_byte = snap_y_q[15:8];
      4'd6:    cur_byte = snap_z_q[7:0];
      4'd7:    cur_byte = snap_z_q[15:8];
      4'd8:    cur_byte = snap_t_q[7:0];
      4'd9:    cur_byte = snap_t_q[15:8];
      default: cur_byte = csum;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      to_q       <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_z_q   <= '0;
      snap_t_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovr_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      to_q       <= to_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      if (!en || cnt_q == CNT_LAST) cnt_q <= '0;
      else                          cnt_q <= cnt_q + 1'b1;
      // All four words latch on the same edge so a frame is always self-consistent.
      if (capture) begin
        snap_x_q <= x_axis_data;
        snap_y_q <= y_axis_data;
        snap_z_q <= z_axis_data;
        snap_t_q <= temp_data;
      end
      if (tick && state_q != S_IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    to_d      = to_q;
    capture   = 1'b0;
    byte_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          to_d    = '0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        // A UART that never acknowledges must not stall the frame forever.
        if (!tx_ready)              state_d   = S_WAIT_DONE;
        else if (to_q == TO_LAST)   byte_done = 1'b1;
        else                        to_d      = to_q + 1'b1;
      end
      S_WAIT_DONE: begin
        if (tx_ready) byte_done = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (byte_done) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_SEND;
      end
    end
  end

  always_comb begin
    tx_start_d = (state_q == S_SEND) && tx_ready;
    tx_data_d  = tx_start_d ? cur_byte : tx_data_q;
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_gyro_frame_packer.sv
// tb/tb_gyro_frame_packer.sv - self-checking bench for gyro_frame_packer
module tb_gyro_frame_packer;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] t_in = 16'hDEF0;
  logic [15:0] x_in = 16'h1234;
  logic [15:0] y_in = 16'h5678;
  logic [15:0] z_in = 16'h9ABC;
  logic        rdy = 1'b1;
  logic        one_l = 1'b1;

  logic [7:0] tx_data, tx_data2, ovr, ovr2;
  logic       tx_start, tx_start2, busy, busy2, frame_done, frame_done2;

  always #5 clk = ~clk;

  gyro_frame_packer #(.PERIOD(P), .ACK_TIMEOUT(1023)) dut (
    .clk(clk), .RST(rst), .en(en),
    .temp_data(t_in), .x_axis_data(x_in), .y_axis_data(y_in), .z_axis_data(z_in),
    .tx_ready(rdy), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .frame_done(frame_done), .overrun_cnt(ovr)
  );

  gyro_frame_packer #(.PERIOD(P), .ACK_TIMEOUT(8)) dut_ack (
    .clk(clk), .RST(rst), .en(en),
    .temp_data(t_in), .x_axis_data(x_in), .y_axis_data(y_in), .z_axis_data(z_in),
    .tx_ready(one_l), .tx_data(tx_data2), .tx_start(tx_start2), .busy(busy2),
    .frame_done(frame_done2), .overrun_cnt(ovr2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: frame phase (0 idle, 1 sending, 2 done pulse), expected bytes, overruns.
  int         cyc = 0;
  int         en_run = 0;
  int         phase = 0;
  int         old_phase;
  int         m_ovr = 0;
  logic [7:0] exp_q[$];
  int         uart_rem = 0;
  int         uart_b = 10;
  int         last_start = -100;
  bit         tick_m, rose;
  logic [7:0] obs_q[$];
  logic [7:0] obs2_q[$];
  int         obs2_cyc[$];
  int         done2_cyc = -1;

  function automatic void push_frame(input logic [15:0] xx, yy, zz, tt);
    int s;
    s = int'(xx[7:0]) + int'(xx[15:8]) + int'(yy[7:0]) + int'(yy[15:8])
      + int'(zz[7:0]) + int'(zz[15:8]) + int'(tt[7:0]) + int'(tt[15:8]);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    exp_q.push_back(xx[7:0]); exp_q.push_back(xx[15:8]);
    exp_q.push_back(yy[7:0]); exp_q.push_back(yy[15:8]);
    exp_q.push_back(zz[7:0]); exp_q.push_back(zz[15:8]);
    exp_q.push_back(tt[7:0]); exp_q.push_back(tt[15:8]);
    exp_q.push_back(8'(s % 256));
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      en_run = 0; phase = 0; m_ovr = 0; exp_q.delete();
      rdy = 1'b1; uart_rem = 0; last_start = -100;
    end
    check("busy", 32'(busy), 32'(phase != 0));
    check("frame_done", 32'(frame_done), 32'(phase == 2));
    check("overrun_cnt", 32'(ovr), 32'(m_ovr));
    if (tx_start === 1'b1) begin
      obs_q.push_back(tx_data);
      if (exp_q.size() == 0 || phase != 1) check("unexpected_start", 32'(tx_start), 32'd0);
      else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      check("start_spacing_ge3", 32'(cyc - last_start >= 3), 32'd1);
      last_start = cyc;
    end
    if (tx_start2 === 1'b1) begin
      obs2_q.push_back(tx_data2);
      obs2_cyc.push_back(cyc);
    end
    if (frame_done2 === 1'b1 && done2_cyc < 0) done2_cyc = cyc;
    if (!rst) begin
      rose = 1'b0;
      if (uart_rem > 0) begin
        uart_rem--;
        if (uart_rem == 0) begin rdy = 1'b1; rose = 1'b1; end
      end
      if (tx_start === 1'b1) begin rdy = 1'b0; uart_rem = uart_b; end
      tick_m = en && (en_run % P == P - 1);
      en_run = en ? en_run + 1 : 0;
      old_phase = phase;
      if (tick_m) begin
        if (old_phase == 0) begin push_frame(x_in, y_in, z_in, t_in); phase = 1; end
        else m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
      end
      if (old_phase == 2) phase = 0;
      else if (old_phase == 1 && rose && exp_q.size() == 0) phase = 2;
    end
  end

  task automatic wait_busy(input logic val, input int limit, input string name);
    int n = 0;
    while (busy !== val && n < limit) begin @(posedge clk); #1; n++; end
    check(name, 32'(busy), 32'(val));
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (frame_done !== 1'b1 && n < limit);
    check(name, 32'(frame_done), 32'd1);
  endtask

  task automatic wait_starts(input int want, input int limit, input string name);
    int n = 0;
    int cnt = 0;
    while (cnt < want && n < limit) begin
      @(posedge clk); #1; n++;
      if (tx_start === 1'b1) cnt++;
    end
    check(name, 32'(cnt), 32'(want));
  endtask

  logic [7:0] golden [11] = '{8'hA5, 8'h5A, 8'h34, 8'h12, 8'h78, 8'h56,
                              8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'h38};

  initial begin
    int n;
    int cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // en low: nothing happens, then first frame starts PERIOD clocks after en rises.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) cnt++;
    end
    check("starts_while_disabled", 32'(cnt), 32'd0);
    check("busy_while_disabled", 32'(busy), 32'd0);
    obs_q.delete(); obs2_q.delete(); obs2_cyc.delete(); done2_cyc = -1;
    en = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (busy !== 1'b1 && n < 100);
    check("en_to_first_frame", 32'(n), 32'(P));

    wait_done(600, "frame1_done");
    check("frame1_len", 32'(obs_q.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < obs_q.size()) check($sformatf("frame1_byte%0d", i), 32'(obs_q[i]), 32'(golden[i]));

    check("ack_frame_len", 32'(obs2_q.size() >= 11), 32'd1);
    if (obs2_q.size() >= 11) begin
      check("ack_first_byte", 32'(obs2_q[0]), 32'hA5);
      check("ack_csum", 32'(obs2_q[10]), 32'h38);
      for (int i = 0; i < 10; i++)
        check($sformatf("ack_spacing%0d", i), 32'(obs2_cyc[i+1] - obs2_cyc[i]), 32'd9);
      check("ack_done_after_last", 32'(done2_cyc - obs2_cyc[10]), 32'd8);
    end

    // Inputs change just after capture: the frame must be unaffected.
    wait_busy(1'b0, 20, "frame1_idle");
    obs_q.delete();
    wait_busy(1'b1, 40, "frame2_start");
    @(posedge clk); #1;
    x_in = 16'h0000; y_in = 16'h0000; z_in = 16'h0000; t_in = 16'h0000;
    wait_done(600, "frame2_done");
    check("frame2_len", 32'(obs_q.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < obs_q.size()) check($sformatf("frame2_byte%0d", i), 32'(obs_q[i]), 32'(golden[i]));

    // Slow UART: many ticks land while busy.
    uart_b = 40;
    wait_busy(1'b0, 20, "frame2_idle");
    obs_q.delete();
    wait_done(1500, "frame3_done");
    check("frame3_csum", 32'(obs_q.size() == 11 ? obs_q[10] : 8'hFF), 32'h00);

    // One stalled byte long enough to saturate the overrun counter.
    uart_b = 5000;
    wait_busy(1'b0, 20, "frame3_idle");
    wait_starts(1, 100, "frame4_first_start");
    @(negedge clk); #1;
    uart_b = 10;
    wait_done(7000, "frame4_done");
    check("overrun_saturated", 32'(ovr), 32'd255);

    // Reset in the middle of byte index 5.
    wait_busy(1'b0, 20, "frame4_idle");
    wait_starts(6, 400, "frame5_six_starts");
    #1 rst = 1'b1;
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(ovr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    wait_starts(1, 100, "post_rst_start");
    check("post_rst_first_byte", 32'(tx_data), 32'hA5);
    wait_done(600, "post_rst_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
